// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: resolves ALU operands (with EX/MEM and MEM/WB
// forwarding) at accept time and buffers up to two issued entries
// (head + skid) so that id_ready can come straight from a flop.
module alu_issue_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [1:0]      id_asel,
  input  logic            id_bsel,
  input  logic [OPW-1:0]  id_alu_op,
  input  logic [4:0]      id_rd,
  input  logic            id_we,
  input  logic            fw1_we,
  input  logic [4:0]      fw1_rd,
  input  logic [XLEN-1:0] fw1_data,
  input  logic            fw2_we,
  input  logic [4:0]      fw2_rd,
  input  logic [XLEN-1:0] fw2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [OPW-1:0]  ex_alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_we
);

  // Idle ALU operation, presented whenever no entry is valid.
  localparam logic [OPW-1:0] ALU_DEFAULT = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One fully resolved instruction; operands are frozen at accept.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic            we;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   ready_q, ready_d;

  logic [XLEN-1:0] r1, r2;
  entry_t          in_entry;
  logic            accept;
  logic            consume;

  // Forwarding and operand muxing for the incoming instruction; x0 never forwards.
  always_comb begin
    r1 = id_rs1_data;
    if (fw1_we && (fw1_rd == id_rs1) && (id_rs1 != 5'd0)) begin
      r1 = fw1_data;
    end else if (fw2_we && (fw2_rd == id_rs1) && (id_rs1 != 5'd0)) begin
      r1 = fw2_data;
    end

    r2 = id_rs2_data;
    if (fw1_we && (fw1_rd == id_rs2) && (id_rs2 != 5'd0)) begin
      r2 = fw1_data;
    end else if (fw2_we && (fw2_rd == id_rs2) && (id_rs2 != 5'd0)) begin
      r2 = fw2_data;
    end

    in_entry.pc = id_pc;
    in_entry.op = id_alu_op;
    in_entry.rd = id_rd;
    in_entry.we = id_we;
    case (id_asel)
      2'd0:    in_entry.a = r1;
      2'd1:    in_entry.a = id_pc;
      default: in_entry.a = '0;
    endcase
    in_entry.b = id_bsel ? id_imm : r2;
  end

  // Occupancy FSM: decides where the incoming entry lands and when the skid drains.
  always_comb begin
    accept  = id_valid && ready_q && !flush;
    consume = (state_q != EMPTY) && ex_ready;
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          head_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    ready_d = (state_d != FULL);
  end

  // State, buffered entries and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  // Head entry drives EX; control fields are forced idle when nothing is valid.
  always_comb begin
    id_ready  = ready_q;
    ex_valid  = (state_q != EMPTY);
    ex_a      = head_q.a;
    ex_b      = head_q.b;
    ex_pc     = head_q.pc;
    ex_rd     = head_q.rd;
    ex_we     = ex_valid && head_q.we;
    ex_alu_op = ex_valid ? head_q.op : ALU_DEFAULT;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [63:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [63:0] id_rs1_data;
   logic [63:0] id_rs2_data;
   logic [1:0]  id_asel;
   logic        id_bsel;
   logic [3:0]  id_alu_op;
   logic [4:0]  id_rd;
   logic        id_we;
   logic        fw1_we;
   logic [4:0]  fw1_rd;
   logic [63:0] fw1_data;
   logic        fw2_we;
   logic [4:0]  fw2_rd;
   logic [63:0] fw2_data;
   logic        ex_valid;
   logic        ex_ready;
   logic [63:0] ex_a;
   logic [63:0] ex_b;
   logic [3:0]  ex_alu_op;
   logic [63:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_we;

   int checkCount;
   int errorCount;

   alu_issue_stage #(.XLEN(64), .OPW(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_asel(id_asel), .id_bsel(id_bsel), .id_alu_op(id_alu_op),
      .id_rd(id_rd), .id_we(id_we),
      .fw1_we(fw1_we), .fw1_rd(fw1_rd), .fw1_data(fw1_data),
      .fw2_we(fw2_we), .fw2_rd(fw2_rd), .fw2_data(fw2_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_we(ex_we)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expectation and tallies the result.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one decoded instruction onto the ID side.
   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [63:0] d1,
                                input logic [4:0] rs2, input logic [63:0] d2,
                                input logic [1:0] asel, input logic bsel,
                                input logic [63:0] pc, input logic [63:0] imm,
                                input logic [3:0] op, input logic [4:0] rd, input logic we);
      id_valid    = v;
      id_rs1      = rs1;
      id_rs1_data = d1;
      id_rs2      = rs2;
      id_rs2_data = d2;
      id_asel     = asel;
      id_bsel     = bsel;
      id_pc       = pc;
      id_imm      = imm;
      id_alu_op   = op;
      id_rd       = rd;
      id_we       = we;
   endtask

   // Advances to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Pushes an entry identified by its rs1 data (asel=0, no forwarding hit).
   task automatic pushTagged(input logic [63:0] tagVal);
      applyStimulus(1'b1, 5'd1, tagVal, 5'd2, 64'h0, 2'd0, 1'b0, tagVal + 64'h1000, 64'h0, 4'h2, 5'd9, 1'b1);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst = 1'b1;
      flush = 1'b0;
      ex_ready = 1'b1;
      fw1_we = 1'b0; fw1_rd = 5'd0; fw1_data = 64'h0;
      fw2_we = 1'b0; fw2_rd = 5'd0; fw2_data = 64'h0;
      applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 64'h0, 2'd0, 1'b0, 64'h0, 64'h0, 4'h0, 5'd0, 1'b0);

      // Reset state
      #12;
      checkOutput("rst_ex_valid", {63'h0, ex_valid}, 64'h0);
      checkOutput("rst_id_ready", {63'h0, id_ready}, 64'h1);
      checkOutput("rst_ex_a", ex_a, 64'h0);
      checkOutput("rst_ex_b", ex_b, 64'h0);
      checkOutput("rst_ex_pc", ex_pc, 64'h0);
      checkOutput("rst_ex_rd", {59'h0, ex_rd}, 64'h0);
      checkOutput("rst_ex_we", {63'h0, ex_we}, 64'h0);
      checkOutput("rst_ex_op", {60'h0, ex_alu_op}, 64'h0);
      rst = 1'b0;
      stepCycle();

      // Basic register operands
      applyStimulus(1'b1, 5'd3, 64'd5, 5'd4, 64'd7, 2'd0, 1'b0, 64'h40, 64'h0, 4'h1, 5'd5, 1'b1);
      stepCycle();
      checkOutput("t1_valid", {63'h0, ex_valid}, 64'h1);
      checkOutput("t1_a", ex_a, 64'd5);
      checkOutput("t1_b", ex_b, 64'd7);
      checkOutput("t1_op", {60'h0, ex_alu_op}, 64'h1);
      checkOutput("t1_rd", {59'h0, ex_rd}, 64'd5);
      checkOutput("t1_we", {63'h0, ex_we}, 64'h1);
      checkOutput("t1_pc", ex_pc, 64'h40);
      id_valid = 1'b0;
      stepCycle();
      checkOutput("t1_drain_valid", {63'h0, ex_valid}, 64'h0);
      checkOutput("t1_drain_we", {63'h0, ex_we}, 64'h0);
      checkOutput("t1_drain_op", {60'h0, ex_alu_op}, 64'h0);

      // Forwarding priority and x0 exclusion
      fw1_we = 1'b1; fw1_rd = 5'd3; fw1_data = 64'h100;
      fw2_we = 1'b1; fw2_rd = 5'd3; fw2_data = 64'h200;
      applyStimulus(1'b1, 5'd3, 64'd5, 5'd3, 64'd6, 2'd0, 1'b0, 64'h0, 64'h0, 4'h1, 5'd1, 1'b1);
      stepCycle();
      checkOutput("t2_fw1_a", ex_a, 64'h100);
      checkOutput("t2_fw1_b", ex_b, 64'h100);
      fw1_we = 1'b0;
      stepCycle();
      checkOutput("t2_fw2_a", ex_a, 64'h200);
      checkOutput("t2_fw2_b", ex_b, 64'h200);
      fw1_we = 1'b1; fw1_rd = 5'd0; fw2_rd = 5'd0;
      applyStimulus(1'b1, 5'd0, 64'h55, 5'd0, 64'h66, 2'd0, 1'b0, 64'h0, 64'h0, 4'h1, 5'd1, 1'b1);
      stepCycle();
      checkOutput("t2_x0_a", ex_a, 64'h55);
      checkOutput("t2_x0_b", ex_b, 64'h66);
      fw1_we = 1'b0; fw2_we = 1'b0;

      // Operand mux selections
      applyStimulus(1'b1, 5'd3, 64'd5, 5'd4, 64'd7, 2'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 4'h3, 5'd2, 1'b1);
      stepCycle();
      checkOutput("t3_a_pc", ex_a, 64'h8000_0000);
      checkOutput("t3_b_imm", ex_b, 64'hFFFF_FFFF_FFFF_FFFC);
      id_asel = 2'd2;
      stepCycle();
      checkOutput("t3_a_zero2", ex_a, 64'h0);
      id_asel = 2'd3; id_bsel = 1'b0;
      stepCycle();
      checkOutput("t3_a_zero3", ex_a, 64'h0);
      checkOutput("t3_b_rs2", ex_b, 64'd7);
      id_valid = 1'b0;
      stepCycle();

      // Backpressure with three back-to-back instructions
      ex_ready = 1'b0;
      pushTagged(64'h10);
      stepCycle();
      checkOutput("t4_i0_a", ex_a, 64'h10);
      checkOutput("t4_ready_one", {63'h0, id_ready}, 64'h1);
      pushTagged(64'h11);
      stepCycle();
      checkOutput("t4_hold_i0", ex_a, 64'h10);
      checkOutput("t4_ready_full", {63'h0, id_ready}, 64'h0);
      pushTagged(64'h12);
      stepCycle();
      checkOutput("t4_stall_i0", ex_a, 64'h10);
      checkOutput("t4_stall_pc", ex_pc, 64'h1010);
      checkOutput("t4_stall_ready", {63'h0, id_ready}, 64'h0);
      ex_ready = 1'b1;
      stepCycle();
      checkOutput("t4_i1_a", ex_a, 64'h11);
      checkOutput("t4_i1_ready", {63'h0, id_ready}, 64'h1);
      stepCycle();
      checkOutput("t4_i2_a", ex_a, 64'h12);
      checkOutput("t4_i2_valid", {63'h0, ex_valid}, 64'h1);
      id_valid = 1'b0;
      stepCycle();
      checkOutput("t4_empty", {63'h0, ex_valid}, 64'h0);

      // Flush while full, with a simultaneous offer
      ex_ready = 1'b0;
      pushTagged(64'h20);
      stepCycle();
      pushTagged(64'h21);
      stepCycle();
      checkOutput("t5_full_ready", {63'h0, id_ready}, 64'h0);
      pushTagged(64'h22);
      flush = 1'b1;
      ex_ready = 1'b1;
      stepCycle();
      checkOutput("t5_valid", {63'h0, ex_valid}, 64'h0);
      checkOutput("t5_ready", {63'h0, id_ready}, 64'h1);
      checkOutput("t5_we", {63'h0, ex_we}, 64'h0);
      checkOutput("t5_op", {60'h0, ex_alu_op}, 64'h0);
      flush = 1'b0;
      id_valid = 1'b0;
      stepCycle();
      checkOutput("t5_dropped", {63'h0, ex_valid}, 64'h0);

      // Asynchronous reset while full
      ex_ready = 1'b0;
      pushTagged(64'h30);
      stepCycle();
      pushTagged(64'h31);
      stepCycle();
      id_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6_valid", {63'h0, ex_valid}, 64'h0);
      checkOutput("t6_ready", {63'h0, id_ready}, 64'h1);
      checkOutput("t6_a", ex_a, 64'h0);
      checkOutput("t6_we", {63'h0, ex_we}, 64'h0);
      checkOutput("t6_pc", ex_pc, 64'h0);
      #3;
      rst = 1'b0;
      stepCycle();
      checkOutput("t6_after_valid", {63'h0, ex_valid}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
